// File: rtl/prefetch_queue_pkg.sv
// prefetch_queue_pkg -- shared types and ring-pointer helper for the prefetch queue; rev 1.0
`default_nettype none

package prefetch_queue_pkg;

  localparam int PREFETCH_DEPTH_V30 = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [3:0] len;
    logic [7:0] q0;
    logic [7:0] q1;
    logic [7:0] q2;
  } prefetch_status_t;

  function automatic logic [3:0] ring_add(input logic [3:0] ptr, input logic [1:0] n,
                                          input logic [4:0] depth);
    logic [4:0] sum;
    sum = {1'b0, ptr} + {3'b000, n};
    if (sum >= depth) sum = sum - depth;
    return sum[3:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/prefetch_queue_if.sv
// prefetch_queue_if -- code-fetch handshake between prefetch queue and bus unit; rev 1.0
`default_nettype none

interface prefetch_queue_if #(
  parameter int ADDR_W = 20
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [15:0]       fetch_data;

  modport master (output fetch_req, fetch_addr, input fetch_ack, fetch_data);
  modport slave  (input fetch_req, fetch_addr, output fetch_ack, fetch_data);
endinterface

`default_nettype wire

// File: rtl/prefetch_queue_ring.sv
// prefetch_ring -- DEPTH-byte circular buffer, 0..2 byte write, 0..3 byte read; rev 1.0
// Optional macro PREFETCH_BYPASS_EN: bytes written into an empty ring show on the outputs at once.
`default_nettype none

module prefetch_ring
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = PREFETCH_DEPTH_V30
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             en,
  input  wire logic             clear,
  input  wire logic [1:0]       wr_cnt,
  input  wire logic [7:0]       wr_b0,
  input  wire logic [7:0]       wr_b1,
  input  wire logic [1:0]       rd_req,
  output prefetch_status_t      status,
  output logic      [3:0]       len_next
);

  logic [7:0] mem [DEPTH];
  logic [3:0] rd_ptr;
  logic [3:0] wr_ptr;
  logic [3:0] len;
  logic [3:0] avail;
  logic [1:0] rd_cnt;

  always_comb begin
`ifdef PREFETCH_BYPASS_EN
    avail = (len == 4'd0) ? {2'b00, wr_cnt} : len;
`else
    avail = len;
`endif
    rd_cnt   = ({2'b00, rd_req} > avail) ? avail[1:0] : rd_req;
    len_next = len + {2'b00, wr_cnt} - {2'b00, rd_cnt};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= 4'd0;
      wr_ptr <= 4'd0;
      len    <= 4'd0;
    end else if (en) begin
      if (clear) begin
        rd_ptr <= 4'd0;
        wr_ptr <= 4'd0;
        len    <= 4'd0;
      end else begin
        rd_ptr <= ring_add(rd_ptr, rd_cnt, 5'(DEPTH));
        wr_ptr <= ring_add(wr_ptr, wr_cnt, 5'(DEPTH));
        len    <= len_next;
      end
    end
  end

  // Storage needs no reset: every read is masked by len.
  always_ff @(posedge clk) begin
    if (en && !clear && wr_cnt != 2'd0) mem[wr_ptr] <= wr_b0;
    if (en && !clear && wr_cnt == 2'd2) mem[ring_add(wr_ptr, 2'd1, 5'(DEPTH))] <= wr_b1;
  end

  always_comb begin
    status.len = len;
    status.q0  = (len > 4'd0) ? mem[rd_ptr] : 8'h00;
    status.q1  = (len > 4'd1) ? mem[ring_add(rd_ptr, 2'd1, 5'(DEPTH))] : 8'h00;
    status.q2  = (len > 4'd2) ? mem[ring_add(rd_ptr, 2'd2, 5'(DEPTH))] : 8'h00;
`ifdef PREFETCH_BYPASS_EN
    if (len == 4'd0 && wr_cnt != 2'd0) begin
      status.len = {2'b00, wr_cnt};
      status.q0  = wr_b0;
      status.q1  = (wr_cnt == 2'd2) ? wr_b1 : 8'h00;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/prefetch_queue.sv
// prefetch_queue -- fetch FSM, prefetch pointer and bus handshake around prefetch_ring; rev 1.0
// Optional macro PREFETCH_BYPASS_EN: ack bytes into an empty queue are visible in the ack cycle.
`default_nettype none

module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH  = PREFETCH_DEPTH_V30,
  parameter int ADDR_W = 20
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              ce,
  input  wire logic              flush,
  input  wire logic [ADDR_W-1:0] flush_addr,
  input  wire logic [1:0]        consume,
  prefetch_queue_if.master       bus,
  output logic      [3:0]        q_len,
  output logic      [7:0]        q0,
  output logic      [7:0]        q1,
  output logic      [7:0]        q2,
  output logic      [ADDR_W-1:0] pfp
);

  fetch_state_t      state;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack_take;
  logic [1:0]        wr_cnt;
  logic [7:0]        wr_b0;
  logic [ADDR_W-1:0] pfp_next;
  logic [3:0]        len_next;
  logic              space_ok;
  prefetch_status_t  status;

  // An odd pfp means the low byte of the returned word precedes the wanted byte.
  always_comb begin
    ack_take = ce && !flush && (state == REQ) && bus.fetch_ack;
    wr_cnt   = ack_take ? (pfp[0] ? 2'd1 : 2'd2) : 2'd0;
    wr_b0    = pfp[0] ? bus.fetch_data[15:8] : bus.fetch_data[7:0];
    pfp_next = pfp + ADDR_W'(wr_cnt);
    space_ok = (5'(DEPTH) - {1'b0, len_next}) >= (pfp_next[0] ? 5'd1 : 5'd2);
  end

  prefetch_ring #(.DEPTH(DEPTH)) u_ring (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (ce),
    .clear    (flush),
    .wr_cnt   (wr_cnt),
    .wr_b0    (wr_b0),
    .wr_b1    (bus.fetch_data[15:8]),
    .rd_req   (consume),
    .status   (status),
    .len_next (len_next)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      req   <= 1'b0;
      addr  <= '0;
      pfp   <= '0;
    end else if (ce) begin
      if (flush) begin
        pfp <= flush_addr;
        req <= 1'b0;
        // A request still in flight must have its late ack swallowed.
        state <= (state != IDLE && !bus.fetch_ack) ? DISCARD : IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (space_ok) begin
              state <= REQ;
              req   <= 1'b1;
              addr  <= {pfp_next[ADDR_W-1:1], 1'b0};
            end
          end
          REQ: begin
            if (bus.fetch_ack) begin
              pfp <= pfp_next;
              if (space_ok) begin
                req  <= 1'b1;
                addr <= {pfp_next[ADDR_W-1:1], 1'b0};
              end else begin
                state <= IDLE;
                req   <= 1'b0;
              end
            end
          end
          DISCARD: begin
            if (bus.fetch_ack) state <= IDLE;
          end
          default: begin
            state <= IDLE;
            req   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.fetch_req  = req;
  assign bus.fetch_addr = addr;
  assign q_len          = status.len;
  assign q0             = status.q0;
  assign q1             = status.q1;
  assign q2             = status.q2;

endmodule

`default_nettype wire

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue -- directed scenarios plus random traffic against a byte-queue reference model.
`default_nettype none

module tb_prefetch_queue;
  import prefetch_queue_pkg::*;

  localparam int DEPTH  = 6;
  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ce;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic [1:0]        consume;
  logic [3:0]        q_len;
  logic [7:0]        q0, q1, q2;
  logic [ADDR_W-1:0] pfp;

  prefetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

  prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .flush      (flush),
    .flush_addr (flush_addr),
    .consume    (consume),
    .bus        (bus),
    .q_len      (q_len),
    .q0         (q0),
    .q1         (q1),
    .q2         (q2),
    .pfp        (pfp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the queue is literally a byte queue.
  byte unsigned      mq[$];
  logic [ADDR_W-1:0] m_pfp;
  bit                m_busy;
  bit                m_disc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int i);
    return (i < mq.size()) ? mq[i] : 8'h00;
  endfunction

  task automatic model_update(input bit c, input bit f, input logic [ADDR_W-1:0] fa,
                              input logic [1:0] cons, input bit ack, input logic [15:0] data);
    int           n;
    int           take;
    bit           wrote;
    bit           left;
    byte unsigned b[2];
    n = 0; take = 0; wrote = 0; left = 0; b[0] = 0; b[1] = 0;
    if (!c) return;
    if (f) begin
      m_disc = m_busy && !ack;
      m_busy = m_disc;
      mq.delete();
      m_pfp = fa;
      return;
    end
    if (ack && m_busy && m_disc) begin
      m_disc = 0;
      m_busy = 0;
      left   = 1;
    end else if (ack && m_busy) begin
      wrote = 1;
      if (m_pfp[0]) begin
        n = 1; b[0] = data[15:8];
      end else begin
        n = 2; b[0] = data[7:0]; b[1] = data[15:8];
      end
    end
`ifdef PREFETCH_BYPASS_EN
    if (mq.size() == 0) begin
      for (int i = 0; i < n; i++) mq.push_back(b[i]);
      take = (int'(cons) < mq.size()) ? int'(cons) : mq.size();
      for (int i = 0; i < take; i++) void'(mq.pop_front());
    end else begin
      take = (int'(cons) < mq.size()) ? int'(cons) : mq.size();
      for (int i = 0; i < take; i++) void'(mq.pop_front());
      for (int i = 0; i < n; i++) mq.push_back(b[i]);
    end
`else
    take = (int'(cons) < mq.size()) ? int'(cons) : mq.size();
    for (int i = 0; i < take; i++) void'(mq.pop_front());
    for (int i = 0; i < n; i++) mq.push_back(b[i]);
`endif
    m_pfp = m_pfp + ADDR_W'(n);
    if (!left && (!m_busy || wrote))
      m_busy = (DEPTH - mq.size()) >= (m_pfp[0] ? 1 : 2);
  endtask

  task automatic check_model();
    chk("q_len", 32'(q_len), mq.size());
    chk("q0", 32'(q0), 32'(mbyte(0)));
    chk("q1", 32'(q1), 32'(mbyte(1)));
    chk("q2", 32'(q2), 32'(mbyte(2)));
    chk("pfp", 32'(pfp), 32'(m_pfp));
    chk("fetch_req", 32'(bus.fetch_req), 32'(m_busy && !m_disc));
    if (m_busy && !m_disc)
      chk("fetch_addr", 32'(bus.fetch_addr), 32'({m_pfp[ADDR_W-1:1], 1'b0}));
    chk("len_bound", 32'(q_len <= 4'(DEPTH)), 32'd1);
  endtask

  task automatic step(input bit c, input bit f, input logic [ADDR_W-1:0] fa,
                      input logic [1:0] cons, input bit ack, input logic [15:0] data);
    ce = c; flush = f; flush_addr = fa; consume = cons;
    bus.fetch_ack = ack; bus.fetch_data = data;
    @(posedge clk);
    model_update(c, f, fa, cons, ack, data);
    #1;
    ce = 1'b1; flush = 1'b0; consume = 2'd0; bus.fetch_ack = 1'b0;
    #1;
    check_model();
  endtask

  // Bounded wait for a request; a stale request being discarded is acked along the way.
  task automatic wait_req();
    for (int i = 0; i < 20 && bus.fetch_req !== 1'b1; i++)
      step(1, 0, '0, 2'd0, m_disc, 16'($urandom));
    chk("req_wait", 32'(bus.fetch_req), 32'd1);
  endtask

  task automatic do_ack(input logic [15:0] data, input logic [1:0] cons);
    wait_req();
    step(1, 0, '0, cons, 1, data);
  endtask

  initial begin
    int hi;
    bit r_ack;
    logic [ADDR_W-1:0] r_fa;

    reset_n = 1'b0; ce = 1'b0; flush = 1'b0; flush_addr = '0; consume = 2'd0;
    bus.fetch_ack = 1'b0; bus.fetch_data = 16'h0;
    mq.delete(); m_pfp = '0; m_busy = 0; m_disc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q_len", 32'(q_len), 32'd0);
    chk("rst_q0", 32'(q0), 32'd0);
    chk("rst_q1", 32'(q1), 32'd0);
    chk("rst_q2", 32'(q2), 32'd0);
    chk("rst_req", 32'(bus.fetch_req), 32'd0);
    chk("rst_addr", 32'(bus.fetch_addr), 32'd0);
    chk("rst_pfp", 32'(pfp), 32'd0);
    reset_n = 1'b1;

    // Fill to capacity from an even address.
    step(1, 1, 20'h00100, 2'd0, 0, 16'h0);
    do_ack(16'hBBAA, 2'd0);
    do_ack(16'hDDCC, 2'd0);
    do_ack(16'hFFEE, 2'd0);
    chk("full_len", 32'(q_len), 32'd6);
    chk("full_q0", 32'(q0), 32'hAA);
    chk("full_q1", 32'(q1), 32'hBB);
    chk("full_q2", 32'(q2), 32'hCC);
    repeat (3) step(1, 0, '0, 2'd0, 0, 16'h0);
    chk("full_noreq", 32'(bus.fetch_req), 32'd0);

    // Odd redirect: only the high byte of the first word is kept.
    step(1, 1, 20'h00101, 2'd0, 0, 16'h0);
    wait_req();
    chk("odd_addr", 32'(bus.fetch_addr), 32'h00100);
    step(1, 0, '0, 2'd0, 1, 16'h3412);
    chk("odd_len", 32'(q_len), 32'd1);
    chk("odd_q0", 32'(q0), 32'h34);
    chk("odd_pfp", 32'(pfp), 32'h00102);
    chk("odd_next_addr", 32'(bus.fetch_addr), 32'h00102);

    // Simultaneous write and consume, with the ring wrapping.
    step(1, 1, 20'h00300, 2'd0, 0, 16'h0);
    do_ack(16'h2211, 2'd0);
    do_ack(16'h4433, 2'd0);
    do_ack(16'h6655, 2'd3);
    chk("wc_len", 32'(q_len), 32'd3);
    chk("wc_q0", 32'(q0), 32'h44);
    do_ack(16'h8877, 2'd2);
    chk("wrap_q0", 32'(q0), 32'h66);
    chk("wrap_q1", 32'(q1), 32'h77);
    chk("wrap_q2", 32'(q2), 32'h88);

    // Flush while a request is outstanding: its ack is swallowed.
    step(1, 1, 20'h00400, 2'd0, 0, 16'h0);
    wait_req();
    chk("dis_addr0", 32'(bus.fetch_addr), 32'h00400);
    step(1, 1, 20'h00500, 2'd0, 0, 16'h0);
    chk("dis_req", 32'(bus.fetch_req), 32'd0);
    step(1, 0, '0, 2'd0, 1, 16'hDEAD);
    chk("dis_len", 32'(q_len), 32'd0);
    chk("dis_pfp", 32'(pfp), 32'h00500);
    step(1, 0, '0, 2'd0, 0, 16'h0);
    chk("dis_newreq", 32'(bus.fetch_req), 32'd1);
    chk("dis_newaddr", 32'(bus.fetch_addr), 32'h00500);

    // Flush and ack in the same cycle.
    step(1, 1, 20'h00600, 2'd0, 1, 16'h5A5A);
    chk("fa_len", 32'(q_len), 32'd0);
    chk("fa_req", 32'(bus.fetch_req), 32'd0);
    step(1, 0, '0, 2'd0, 0, 16'h0);
    chk("fa_req2", 32'(bus.fetch_req), 32'd1);
    chk("fa_addr", 32'(bus.fetch_addr), 32'h00600);

    // Clock enable low freezes everything.
    step(1, 0, '0, 2'd0, 1, 16'hA1B2);
    repeat (5) step(0, 0, '0, 2'd1, 1, 16'hFFFF);
    chk("ce_len", 32'(q_len), 32'd2);
    chk("ce_q0", 32'(q0), 32'hB2);
    chk("ce_pfp", 32'(pfp), 32'h00602);
    chk("ce_req", 32'(bus.fetch_req), 32'd1);

    // Ack into an empty queue: same-cycle visibility only with the bypass.
    step(1, 1, 20'h00700, 2'd0, 0, 16'h0);
    wait_req();
    consume = 2'd1; bus.fetch_ack = 1'b1; bus.fetch_data = 16'h2211;
    #1;
`ifdef PREFETCH_BYPASS_EN
    chk("byp_len", 32'(q_len), 32'd2);
    chk("byp_q0", 32'(q0), 32'h11);
    chk("byp_q1", 32'(q1), 32'h22);
`else
    chk("nobyp_len", 32'(q_len), 32'd0);
    chk("nobyp_q0", 32'(q0), 32'h00);
`endif
    step(1, 0, '0, 2'd1, 1, 16'h2211);

    // Random traffic.
    repeat (800) begin
      hi    = (mq.size() < 3) ? mq.size() : 3;
      r_ack = m_busy && ($urandom % 2 == 0);
      r_fa  = ($urandom % 4 == 0) ? 20'hFFFFF : ADDR_W'($urandom);
      step(($urandom % 8) != 0, ($urandom % 32) == 0, r_fa,
           2'($urandom_range(hi, 0)), r_ack, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
